// File: rtl/mdu_pkg.sv
// Shared MDU opcode encoding, scheduler states and long-op decode helper.
// MDU_MADD_EN: when defined, the MADD/MADDU/MSUB/MSUBU family is decoded as long ops.
package mdu_pkg;

    localparam logic [3:0] MDOP_NONE  = 4'd0;
    localparam logic [3:0] MDOP_MULT  = 4'd1;
    localparam logic [3:0] MDOP_MULTU = 4'd2;
    localparam logic [3:0] MDOP_DIV   = 4'd3;
    localparam logic [3:0] MDOP_DIVU  = 4'd4;
    localparam logic [3:0] MDOP_MFHI  = 4'd5;
    localparam logic [3:0] MDOP_MFLO  = 4'd6;
    localparam logic [3:0] MDOP_MTHI  = 4'd7;
    localparam logic [3:0] MDOP_MTLO  = 4'd8;
    localparam logic [3:0] MDOP_MADD  = 4'd9;
    localparam logic [3:0] MDOP_MADDU = 4'd10;
    localparam logic [3:0] MDOP_MSUB  = 4'd11;
    localparam logic [3:0] MDOP_MSUBU = 4'd12;

`ifdef MDU_MADD_EN
    localparam logic MADD_EN = 1'b1;
`else
    localparam logic MADD_EN = 1'b0;
`endif

    typedef enum logic {ST_IDLE, ST_BUSY} mdu_state_e;

    function automatic logic is_madd_op(input logic [3:0] op);
        return MADD_EN && (op inside {MDOP_MADD, MDOP_MADDU, MDOP_MSUB, MDOP_MSUBU});
    endfunction

    function automatic logic is_long_op(input logic [3:0] op);
        return (op inside {MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU}) || is_madd_op(op);
    endfunction

endpackage

// File: rtl/mdu_busy_cnt.sv
// Loadable 4-bit down-counter tracking the remaining MDU busy cycles.
module mdu_busy_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= 4'd0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mdu_sched.sv
// MIPS multiply/divide scheduler: owns HI/LO, models MULT/DIV latency, stalls D-stage MDU users.
// MDU_MADD_EN (see mdu_pkg) enables the MADD/MSUB family with MULT_CYCLES latency.
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_mdop,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md_use,
    output logic        stall_req,
    output logic        busy,
    output logic [31:0] E_md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES - 1);

    mdu_state_e  state;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_ok;
    logic        cnt_zero;
    logic        start;

    logic [63:0] sprod, uprod, acc;
    logic [31:0] a_mag, b_mag, sdiv_b, udiv_b, mq, mr, uq, ur;
    logic [31:0] res_hi, res_lo;
    logic        res_ok;

    assign sprod  = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    assign uprod  = {32'd0, E_A} * {32'd0, E_B};
    assign acc    = {hi, lo};

    // Signed divide done on magnitudes so INT_MIN / -1 wraps to INT_MIN, remainder 0.
    assign a_mag  = E_A[31] ? (32'd0 - E_A) : E_A;
    assign b_mag  = E_B[31] ? (32'd0 - E_B) : E_B;
    assign sdiv_b = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign udiv_b = (E_B == 32'd0) ? 32'd1 : E_B;
    assign mq     = a_mag / sdiv_b;
    assign mr     = a_mag % sdiv_b;
    assign uq     = E_A / udiv_b;
    assign ur     = E_A % udiv_b;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_ok = 1'b1;
        case (E_mdop)
            MDOP_MULT:  {res_hi, res_lo} = sprod;
            MDOP_MULTU: {res_hi, res_lo} = uprod;
            MDOP_DIV: begin
                res_ok = (E_B != 32'd0);
                res_lo = (E_A[31] ^ E_B[31]) ? (32'd0 - mq) : mq;
                res_hi = E_A[31] ? (32'd0 - mr) : mr;
            end
            MDOP_DIVU: begin
                res_ok = (E_B != 32'd0);
                res_lo = uq;
                res_hi = ur;
            end
            MDOP_MADD:  {res_hi, res_lo} = acc + sprod;
            MDOP_MADDU: {res_hi, res_lo} = acc + uprod;
            MDOP_MSUB:  {res_hi, res_lo} = acc - sprod;
            MDOP_MSUBU: {res_hi, res_lo} = acc - uprod;
            default: ;
        endcase
    end

    assign start = (state == ST_IDLE) && is_long_op(E_mdop);

    mdu_busy_cnt u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_val ((E_mdop inside {MDOP_DIV, MDOP_DIVU}) ? DIV_LD : MULT_LD),
        .dec      (state == ST_BUSY),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_ok <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        pend_ok <= res_ok;
                        state   <= ST_BUSY;
                    end else if (E_mdop == MDOP_MTHI) begin
                        hi <= E_A;
                    end else if (E_mdop == MDOP_MTLO) begin
                        lo <= E_A;
                    end
                end
                // Any opcode seen here is a protocol violation and is ignored.
                ST_BUSY: begin
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                        if (pend_ok) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state == ST_BUSY);
    assign stall_req  = D_md_use && (busy || is_long_op(E_mdop));
    assign E_md_rdata = (E_mdop == MDOP_MFHI) ? hi :
                        (E_mdop == MDOP_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized and directed bench for mdu_sched against a cycle-count reference model.
module tb_mdu_sched;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_mdop;
    logic [31:0] E_A, E_B;
    logic        D_md_use;
    logic        stall_req, busy;
    logic [31:0] E_md_rdata, hi, lo;

    mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_mdop     (E_mdop),
        .E_A        (E_A),
        .E_B        (E_B),
        .D_md_use   (D_md_use),
        .stall_req  (stall_req),
        .busy       (busy),
        .E_md_rdata (E_md_rdata),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: remaining busy cycles plus pending result
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_ok;
    int          rem;

    function automatic bit ref_long(input logic [3:0] op);
        if (op >= 4'd1 && op <= 4'd4) return 1'b1;
        if (MADD_ON && op >= 4'd9 && op <= 4'd12) return 1'b1;
        return 1'b0;
    endfunction

    task automatic ref_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up, hl;
        int              sa, sb;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(a) * 64'(b);
        hl = {m_hi, m_lo};
        p_ok = 1'b1;
        case (op)
            4'd1: {p_hi, p_lo} = sp;
            4'd2: {p_hi, p_lo} = up;
            4'd3: begin
                if (b == 0) p_ok = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    p_lo = 32'h8000_0000; p_hi = 32'd0;
                end else begin
                    sa = a; sb = b;
                    p_lo = sa / sb; p_hi = sa % sb;
                end
            end
            4'd4: begin
                if (b == 0) p_ok = 1'b0;
                else begin p_lo = a / b; p_hi = a % b; end
            end
            4'd9:  {p_hi, p_lo} = hl + sp;
            4'd10: {p_hi, p_lo} = hl + up;
            4'd11: {p_hi, p_lo} = hl - sp;
            default: {p_hi, p_lo} = hl - up;
        endcase
        rem = (op == 4'd3 || op == 4'd4) ? DC : MC;
    endtask

    task automatic ref_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (rem > 0) begin
            rem--;
            if (rem == 0 && p_ok) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (ref_long(op)) ref_compute(op, a, b);
        else if (op == 4'd7) m_hi = a;
        else if (op == 4'd8) m_lo = a;
    endtask

    task automatic ref_reset();
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_ok = 0; rem = 0;
    endtask

    // Called at posedge+1; checks mid-cycle, then advances model across the next edge.
    task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic d);
        logic [31:0] exp_rd;
        E_mdop = op; E_A = a; E_B = b; D_md_use = d;
        #3;
        exp_rd = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        chk("busy", {31'd0, busy}, {31'd0, rem > 0});
        chk("stall_req", {31'd0, stall_req}, {31'd0, d && (rem > 0 || ref_long(op))});
        chk("rdata", E_md_rdata, exp_rd);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        @(posedge clk);
        ref_step(op, a, b);
        #1;
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) cyc(MDOP_NONE, 32'd0, 32'd0, d);
    endtask

    initial begin
        reset = 1'b0; E_mdop = MDOP_NONE; E_A = 0; E_B = 0; D_md_use = 1'b0;
        ref_reset();
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        cyc(MDOP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0); idle(MC, 1'b0);
        chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFFA);

        cyc(MDOP_DIVU, 32'd100, 32'd7, 1'b0); idle(DC, 1'b0);
        chk("divu_lo", lo, 32'd14); chk("divu_hi", hi, 32'd2);

        cyc(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0); idle(DC, 1'b0);
        chk("div_lo", lo, 32'hFFFF_FFFD); chk("div_hi", hi, 32'hFFFF_FFFF);

        cyc(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); idle(DC, 1'b0);
        chk("divovf_lo", lo, 32'h8000_0000); chk("divovf_hi", hi, 32'd0);

        cyc(MDOP_MTHI, 32'h11, 32'd0, 1'b0); cyc(MDOP_MTLO, 32'h22, 32'd0, 1'b0);
        cyc(MDOP_DIV, 32'd55, 32'd0, 1'b0); idle(DC, 1'b0);
        chk("div0_hi", hi, 32'h11); chk("div0_lo", lo, 32'h22);

        cyc(MDOP_MULT, 32'd7, 32'd6, 1'b1); idle(MC, 1'b1);
        cyc(MDOP_MFLO, 32'd0, 32'd0, 1'b1);
        chk("mflo_after_stall", E_md_rdata, 32'd42);

        cyc(MDOP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
        chk("mthi", hi, 32'hDEAD_BEEF); chk("mthi_busy", {31'd0, busy}, 32'd0);

        cyc(MDOP_MTHI, 32'd0, 32'd0, 1'b0); cyc(MDOP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
        cyc(MDOP_MADDU, 32'd1, 32'd1, 1'b0); idle(MC, 1'b0);
        chk("maddu_hi", hi, MADD_ON ? 32'd1 : 32'd0);
        chk("maddu_lo", lo, MADD_ON ? 32'd0 : 32'hFFFF_FFFF);

        cyc(MDOP_MTHI, 32'h1234, 32'd0, 1'b0);
        cyc(MDOP_DIV, 32'd50, 32'd3, 1'b0); idle(3, 1'b0);
        reset = 1'b0; #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0); chk("midrst_lo", lo, 32'd0);
        ref_reset();
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        idle(DC + 1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            cyc(op, a, b, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide scheduler for the five-stage MIPS pipeline. It accepts MDU operations from the E stage and owns the HI/LO architectural registers. It models multi-cycle MULT/DIV latency with a busy counter and raises a stall request toward the D-stage hazard logic whenever a D-stage instruction needs the MDU before it is free.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MSUB family); legal range 1..15
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low reset
- E_mdop  input  4  MDU opcode of the instruction in E; MDOP_NONE when E holds no MDU instruction
- E_A  input  32  forwarded rs value in E (E_fixedRD1)
- E_B  input  32  forwarded rt value in E (E_fixedRD2)
- D_md_use  input  1  D-stage instruction is any MDU opcode (mult/div/mf/mt/madd family)
- stall_req  output  1  OR'd into D_stall by the hazard unit
- busy  output  1  long operation in progress
- E_md_rdata  output  32  HI for MDOP_MFHI, LO for MDOP_MFLO, else 0
- hi, lo  output  32 each  architectural HI/LO, for debug and trace

## Operation
- State machine: IDLE, BUSY.
- IDLE with E_mdop ∈ {MULT, MULTU, DIV, DIVU}:
  - Results are computed combinationally from E_A/E_B and latched into pending_hi/pending_lo at the edge.
  - cnt loads N−1 (N = MULT_CYCLES or DIV_CYCLES) and the state moves to BUSY.
- BUSY: cnt decrements each edge. At the edge where cnt==0, HI/LO load the pending values and the state returns to IDLE.
- Arithmetic:
  - MULT: signed 32×32→64, HI = [63:32], LO = [31:0]. MULTU is the unsigned form.
  - DIV: LO = quotient, HI = remainder, truncated toward zero; remainder sign follows the dividend. DIVU is the unsigned form.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - Divide by zero still occupies DIV_CYCLES and leaves HI/LO unchanged; pending values are not committed.
- MTHI/MTLO in IDLE: HI (resp. LO) ← E_A at the edge, with no busy period.
- MFHI/MFLO: E_md_rdata is purely combinational from current hi/lo.
- stall_req = D_md_use && (busy || E_mdop ∈ {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU}).
  - This guarantees no MDU opcode reaches E while busy.
  - Any MDU opcode arriving in E while busy is a protocol violation. It is ignored: no state change, and E_md_rdata returns the stale value.
- Writes to GRF from MFHI/MFLO flow through the normal E→M→W path. The block itself never touches GRF.

## Timing
- Reset (reset low, asynchronous): hi = 0, lo = 0, pending = 0, cnt = 0, state IDLE, busy = 0, stall_req = 0 (given D_md_use = 0).
- A long op present in E at edge t0 asserts busy from t0 for exactly N cycles, deasserting at edge t0+N. HI/LO update at that same edge t0+N.
- An MFHI in D behind a MULT in E stalls through N+1 D-cycles, then reads the committed value in E with no extra bubble.
- Reset asserted mid-BUSY aborts the operation; pending results are discarded.
- Same-cycle MTHI and completion cannot occur (stall guarantees). If forced, completion wins.

## Configuration
- MDU_MADD_EN defined: MADD, MADDU, MSUB, MSUBU are decoded.
  - {HI,LO} ± (signed or unsigned) E_A×E_B is captured into pending at start, using the HI/LO value at start.
  - They run with MULT_CYCLES latency.
- Undefined: these four opcodes are treated as MDOP_NONE, with no busy period and no stall contribution.

## Structure
- Shared package mdu_pkg holds:
  - MDOP_* 4-bit localparams (NONE=0, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU)
  - state encoding
  - the is_long_op() function, also used by the control decoder
- One sub-module, mdu_busy_cnt: a loadable 4-bit down-counter with load/zero flags, instantiated once.
- The multiply/divide arithmetic stays inline in mdu_sched.

## Test plan
- MULT E_A=0xFFFFFFFE (−2), E_B=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU E_A=100, E_B=7 → busy 10 cycles; then lo=14, hi=2. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV E_B=0 with prior hi=0x11, lo=0x22 → busy 10 cycles; hi/lo remain 0x11/0x22.
- MULT in E with D_md_use=1 → stall_req high in the same cycle and stays high until the edge busy falls; MFLO then returns the new lo.
- MTHI E_A=0xDEADBEEF in IDLE → hi=0xDEADBEEF next edge, busy stays 0. Reset pulse mid-DIV (cycle 4) → busy=0 and hi=lo=0 immediately.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0 after 5 cycles. Without it, the same opcode gives no busy and no change.
